accumulator_bank: RTL and testbench

Multi-channel, saturating successor to the single-register accumulator in the DSP datapath. Holds N independent signed W-bit accumulators selected per operation, supports clear/load/add/subtract/absolute/read plus a sequenced clear-all, and reports overflow per operation and per channel. Sits between the filter/MAC stages and the result readout, one operation accepted per clock.

---
 rtl/dsp_acc_pkg.sv | 41 ++++
 rtl/acc_alu.sv | 43 ++++
 rtl/accumulator_bank.sv | 93 +++++++++
 tb/tb_accumulator_bank.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dsp_acc_pkg.sv
// Shared definitions for the multi-channel accumulator bank: op codes,
// controller states and the overflow/saturation helper.
package dsp_acc_pkg;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_CLR    = 3'd1;
   localparam logic [2:0] OP_LOAD   = 3'd2;
   localparam logic [2:0] OP_ADD    = 3'd3;
   localparam logic [2:0] OP_SUB    = 3'd4;
   localparam logic [2:0] OP_ABS    = 3'd5;
   localparam logic [2:0] OP_CLRALL = 3'd6;
   localparam logic [2:0] OP_READ   = 3'd7;

   typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

   typedef struct packed {
      logic               ovf;
      logic signed [63:0] val;
   } sat_t;

   // Range-checks a sign-extended value against a w-bit signed range and
   // either clamps it or wraps it to the low w bits (w must be below 64).
   function automatic sat_t sat_w(input logic signed [63:0] value, input int w, input bit sat);
      sat_t               r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] wrapped;
      hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo      = -hi - 64'sd1;
      wrapped = (value <<< (64 - w)) >>> (64 - w);
      r.ovf   = (value > hi) || (value < lo);
      if (!r.ovf)
         r.val = value;
      else if (sat)
         r.val = value[63] ? lo : hi;
      else
         r.val = wrapped;
      return r;
   endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational next-value computation for one accumulator channel,
// evaluated one bit wider than the channel so overflow is never lost.
module acc_alu
   import dsp_acc_pkg::*;
#(
   parameter int W   = 32,
   parameter bit SAT = 1'b1
) (
   input  logic [2:0]          op,
   input  logic signed [W-1:0] acc,
   input  logic signed [W-1:0] in,
   output logic signed [W-1:0] next,
   output logic                ovf
);

   logic signed [W:0] acc_x;
   logic signed [W:0] in_x;
   logic signed [W:0] wide;
   sat_t              res;

   assign acc_x = {acc[W-1], acc};
   assign in_x  = {in[W-1], in};

   always_comb begin
      wide = acc_x;
      case (op)
         OP_CLR:  wide = '0;
         OP_LOAD: wide = in_x;
         OP_ADD:  wide = acc_x + in_x;
         OP_SUB:  wide = acc_x - in_x;
         // The most negative value negates to +2^(W-1), caught as overflow below
         OP_ABS:  wide = acc[W-1] ? -acc_x : acc_x;
         default: wide = acc_x;
      endcase
   end

   always_comb begin
      res  = sat_w(64'(wide), W, SAT);
      next = res.val[W-1:0];
      ovf  = res.ovf;
   end

endmodule

// File: rtl/accumulator_bank.sv
// N-channel saturating accumulator bank: one operation per clock, a
// sequenced clear-all sweep, and per-result plus per-channel overflow flags.
module accumulator_bank
   import dsp_acc_pkg::*;
#(
   parameter int W   = 32,
   parameter int N   = 4,
   parameter bit SAT = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2:0]           op,
   input  logic [$clog2(N)-1:0] ch,
   input  logic [W-1:0]         in,
   output logic                 out_valid,
   output logic [$clog2(N)-1:0] out_ch,
   output logic [W-1:0]         out,
   output logic                 ovf,
   output logic [N-1:0]         ovf_sticky
);

   localparam int CW = $clog2(N);

   state_t              state;
   logic [CW-1:0]       idx;
   logic signed [W-1:0] acc [N];
   logic signed [W-1:0] acc_sel;
   logic signed [W-1:0] alu_next;
   logic                alu_ovf;
   logic                accept;

   assign acc_sel  = acc[ch];
   assign in_ready = (state == ST_IDLE);
   assign accept   = in_valid && in_ready;

   acc_alu #(
      .W   (W),
      .SAT (SAT)
   ) u_alu (
      .op   (op),
      .acc  (acc_sel),
      .in   (in),
      .next (alu_next),
      .ovf  (alu_ovf)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         idx        <= '0;
         for (int i = 0; i < N; i++) acc[i] <= '0;
         ovf_sticky <= '0;
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out        <= '0;
         ovf        <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (op == OP_CLRALL) begin
                     state <= ST_SWEEP;
                     idx   <= '0;
                  end else if (op != OP_NOP) begin
                     acc[ch]   <= alu_next;
                     out_valid <= 1'b1;
                     out       <= alu_next;
                     out_ch    <= ch;
                     ovf       <= alu_ovf;
                     if (op == OP_CLR || op == OP_LOAD)
                        ovf_sticky[ch] <= 1'b0;
                     else if (alu_ovf)
                        ovf_sticky[ch] <= 1'b1;
                  end
               end
            end
            // One channel per cycle, lowest index first; input is stalled throughout
            ST_SWEEP: begin
               acc[idx]        <= '0;
               ovf_sticky[idx] <= 1'b0;
               idx             <= idx + CW'(1);
               if (idx == CW'(N - 1))
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed bench: a saturating and a wrapping bank (W=8, N=4) driven in lockstep.
module tb_accumulator_bank;

   localparam int W = 8;
   localparam int N = 4;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] op       = 3'd0;
   logic [1:0] ch       = 2'd0;
   logic [7:0] din      = 8'd0;

   logic       s_ready, s_valid, s_ovf, w_ready, w_valid, w_ovf;
   logic [1:0] s_ch, w_ch;
   logic [7:0] s_out, w_out;
   logic [3:0] s_sticky, w_sticky;

   int checks = 0;
   int errors = 0;
   int cnt;

   always #5 clk = ~clk;

   accumulator_bank #(.W(W), .N(N), .SAT(1'b1)) u_sat (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_ready),
      .op(op), .ch(ch), .in(din), .out_valid(s_valid), .out_ch(s_ch),
      .out(s_out), .ovf(s_ovf), .ovf_sticky(s_sticky)
   );

   accumulator_bank #(.W(W), .N(N), .SAT(1'b0)) u_wrap (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_ready),
      .op(op), .ch(ch), .in(din), .out_valid(w_valid), .out_ch(w_ch),
      .out(w_out), .ovf(w_ovf), .ovf_sticky(w_sticky)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [1:0] c, input logic [7:0] v);
      in_valid = 1'b1;
      op       = o;
      ch       = c;
      din      = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic result(input string tag, input logic [1:0] c, input logic [7:0] es,
                         input logic [7:0] ew, input logic os, input logic ow);
      check({tag, ".valid_s"}, 32'(s_valid), 32'd1);
      check({tag, ".valid_w"}, 32'(w_valid), 32'd1);
      check({tag, ".ch_s"},    32'(s_ch),    32'(c));
      check({tag, ".ch_w"},    32'(w_ch),    32'(c));
      check({tag, ".out_s"},   32'(s_out),   32'(es));
      check({tag, ".out_w"},   32'(w_out),   32'(ew));
      check({tag, ".ovf_s"},   32'(s_ovf),   32'(os));
      check({tag, ".ovf_w"},   32'(w_ovf),   32'(ow));
   endtask

   task automatic sticky(input string tag, input logic [3:0] es, input logic [3:0] ew);
      check({tag, ".sticky_s"}, 32'(s_sticky), 32'(es));
      check({tag, ".sticky_w"}, 32'(w_sticky), 32'(ew));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst.ready_s", 32'(s_ready), 32'd1);
      check("rst.ready_w", 32'(w_ready), 32'd1);
      check("rst.valid_s", 32'(s_valid), 32'd0);
      check("rst.out_s",   32'(s_out),   32'd0);
      check("rst.ovf_w",   32'(w_ovf),   32'd0);
      sticky("rst", 4'b0000, 4'b0000);

      // 1: overflow on ADD, clamp vs wrap
      issue(3'd2, 2'd1, 8'd100);
      result("t1.load", 2'd1, 8'd100, 8'd100, 1'b0, 1'b0);
      issue(3'd3, 2'd1, 8'd100);
      result("t1.add", 2'd1, 8'h7F, 8'hC8, 1'b1, 1'b1);
      sticky("t1", 4'b0010, 4'b0010);

      // 2: ABS of the most negative value, then a normal ABS
      issue(3'd2, 2'd2, 8'h80);
      result("t2.load", 2'd2, 8'h80, 8'h80, 1'b0, 1'b0);
      issue(3'd5, 2'd2, 8'h00);
      result("t2.absmin", 2'd2, 8'h7F, 8'h80, 1'b1, 1'b1);
      sticky("t2a", 4'b0110, 4'b0110);
      issue(3'd2, 2'd2, 8'hFB);
      sticky("t2b", 4'b0010, 4'b0010);
      issue(3'd5, 2'd2, 8'h00);
      result("t2.abs", 2'd2, 8'h05, 8'h05, 1'b0, 1'b0);

      // 3: CLR, LOAD, SUB, READ, NOP
      issue(3'd1, 2'd1, 8'h55);
      result("t3.clr1", 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);
      issue(3'd1, 2'd2, 8'h00);
      sticky("t3", 4'b0000, 4'b0000);
      issue(3'd2, 2'd0, 8'd5);
      issue(3'd2, 2'd3, 8'hFD);
      issue(3'd4, 2'd0, 8'd7);
      result("t3.sub", 2'd0, 8'hFE, 8'hFE, 1'b0, 1'b0);
      issue(3'd7, 2'd3, 8'h12);
      result("t3.read3", 2'd3, 8'hFD, 8'hFD, 1'b0, 1'b0);
      issue(3'd0, 2'd1, 8'h44);
      check("t3.nop_s", 32'(s_valid), 32'd0);
      check("t3.nop_w", 32'(w_valid), 32'd0);
      issue(3'd7, 2'd1, 8'h00);
      result("t3.read1", 2'd1, 8'h00, 8'h00, 1'b0, 1'b0);
      issue(3'd7, 2'd2, 8'h00);
      result("t3.read2", 2'd2, 8'h00, 8'h00, 1'b0, 1'b0);

      // 4: back-to-back ADDs on one channel
      issue(3'd1, 2'd0, 8'h00);
      for (int i = 1; i <= 10; i++) begin
         issue(3'd3, 2'd0, 8'(i));
         result($sformatf("t4.add%0d", i), 2'd0, 8'(i * (i + 1) / 2), 8'(i * (i + 1) / 2), 1'b0, 1'b0);
      end

      // 5: CLRALL with an ADD held on the input during the sweep
      issue(3'd2, 2'd1, 8'd50);
      issue(3'd2, 2'd2, 8'hF9);
      issue(3'd2, 2'd3, 8'd120);
      issue(3'd3, 2'd3, 8'd20);
      result("t5.pre", 2'd3, 8'h7F, 8'h8C, 1'b1, 1'b1);
      issue(3'd6, 2'd0, 8'h00);
      in_valid = 1'b1;
      op       = 3'd3;
      ch       = 2'd0;
      din      = 8'd5;
      cnt      = 0;
      while (s_ready === 1'b0 && cnt < 10) begin
         check($sformatf("t5.sweep%0d.valid_s", cnt), 32'(s_valid), 32'd0);
         check($sformatf("t5.sweep%0d.ready_w", cnt), 32'(w_ready), 32'd0);
         cnt++;
         @(posedge clk);
         #1;
      end
      check("t5.stall_cycles", 32'(cnt), 32'd4);
      check("t5.ready_w", 32'(w_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      result("t5.add", 2'd0, 8'd5, 8'd5, 1'b0, 1'b0);
      sticky("t5", 4'b0000, 4'b0000);
      for (int c = 1; c < 4; c++) begin
         issue(3'd7, 2'(c), 8'h00);
         result($sformatf("t5.read%0d", c), 2'(c), 8'h00, 8'h00, 1'b0, 1'b0);
      end

      // 6: reset in the second sweep cycle
      issue(3'd2, 2'd3, 8'h7F);
      issue(3'd3, 2'd3, 8'h01);
      result("t6.pre", 2'd3, 8'h7F, 8'h80, 1'b1, 1'b1);
      issue(3'd6, 2'd0, 8'h00);
      check("t6.sweep_ready", 32'(s_ready), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("t6.ready_s", 32'(s_ready), 32'd1);
      check("t6.ready_w", 32'(w_ready), 32'd1);
      check("t6.valid_s", 32'(s_valid), 32'd0);
      check("t6.out_s",   32'(s_out),   32'd0);
      check("t6.out_w",   32'(w_out),   32'd0);
      check("t6.ch_s",    32'(s_ch),    32'd0);
      check("t6.ovf_s",   32'(s_ovf),   32'd0);
      check("t6.ovf_w",   32'(w_ovf),   32'd0);
      sticky("t6", 4'b0000, 4'b0000);
      for (int c = 0; c < 4; c++) begin
         issue(3'd7, 2'(c), 8'h00);
         result($sformatf("t6.read%0d", c), 2'(c), 8'h00, 8'h00, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
